// File: rtl/ipi_mailbox.sv
// Inter-processor interrupt mailbox: per-core SEND_MASK/TX_DATA/RX_DATA/STATUS CSRs feeding per-core RX FIFOs.
// Response one cycle after acceptance; req_ready drops only while a response is pending or a TX write loses arbitration.
module ipi_mailbox #(
  parameter int CORES      = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CORES-1:0]       csr_req_valid_i,
  output logic [CORES-1:0]       csr_req_ready_o,
  input  logic [CORES-1:0]       csr_req_write_i,
  input  logic [CORES-1:0][31:0] csr_req_addr_i,
  input  logic [CORES-1:0][31:0] csr_req_wdata_i,
  input  logic [CORES-1:0][3:0]  csr_req_wstrb_i,
  input  logic [CORES-1:0][1:0]  csr_req_priv_i,
  output logic [CORES-1:0]       csr_rsp_valid_o,
  output logic [CORES-1:0][31:0] csr_rsp_rdata_o,
  output logic [CORES-1:0]       csr_rsp_fault_o,
  output logic [CORES-1:0]       ipi_irq_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [CORES-1:0][FIFO_DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [CORES-1:0][PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CORES-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [CORES-1:0][CORES-1:0] mask_q, mask_d;
  logic [CORES-1:0][31:0]      rdata_q, rdata_d;
  logic [CORES-1:0]            drop_q, drop_d, drop_set, drop_clr;
  logic [CORES-1:0]            pend_q, fault_q, fault_d, irq_q, irq_d;
  logic [CORES-1:0]            push_en, pop_en, tx_cand, tx_grant, acc;
  logic [DATA_W-1:0]           tx_word;
  logic                        unused_bits;

  assign unused_bits = ^{csr_req_priv_i, csr_req_addr_i, csr_req_wdata_i};

  // Any TX_DATA write competes, even one that will fault on wstrb; lowest index wins.
  always_comb begin
    tx_cand = '0;
    for (int i = 0; i < CORES; i++) begin
      tx_cand[i] = csr_req_valid_i[i] & ~pend_q[i] & csr_req_write_i[i] &
                   (csr_req_addr_i[i][7:0] == 8'h04);
    end
    tx_grant = tx_cand & (~tx_cand + 1'b1);
  end

  assign csr_req_ready_o = ~pend_q & ~(tx_cand & ~tx_grant);
  assign acc             = csr_req_valid_i & csr_req_ready_o;

  always_comb begin
    mask_d   = mask_q;
    drop_set = '0;
    drop_clr = '0;
    push_en  = '0;
    pop_en   = '0;
    rdata_d  = '0;
    fault_d  = '0;
    tx_word  = '0;
    for (int i = 0; i < CORES; i++) begin
      if (acc[i]) begin
        case (csr_req_addr_i[i][7:0])
          8'h00: begin
            if (csr_req_write_i[i]) begin
              for (int c = 0; c < CORES; c++) begin
                if (csr_req_wstrb_i[i][c/8]) mask_d[i][c] = csr_req_wdata_i[i][c];
              end
            end else begin
              rdata_d[i][CORES-1:0] = mask_q[i];
            end
          end
          8'h04: begin
            if (csr_req_write_i[i]) begin
              if (csr_req_wstrb_i[i] == 4'hF) begin
                tx_word = csr_req_wdata_i[i][DATA_W-1:0];
                for (int d = 0; d < CORES; d++) begin
                  if (mask_q[i][d]) begin
                    if (cnt_q[d] == FULL_CNT) drop_set[i] = 1'b1;
                    else                      push_en[d]  = 1'b1;
                  end
                end
              end else begin
                fault_d[i] = 1'b1;
              end
            end
          end
          8'h08: begin
            if (csr_req_write_i[i]) begin
              fault_d[i] = 1'b1;
            end else if (cnt_q[i] != '0) begin
              rdata_d[i][DATA_W-1:0] = mem_q[i][rptr_q[i]];
              pop_en[i]              = 1'b1;
            end
          end
          8'h0C: begin
            if (csr_req_write_i[i]) begin
              drop_clr[i] = csr_req_wstrb_i[i][2] & csr_req_wdata_i[i][16];
            end else begin
              rdata_d[i][0]       = (cnt_q[i] != '0);
              rdata_d[i][1]       = (cnt_q[i] == FULL_CNT);
              rdata_d[i][8 +: CW] = cnt_q[i];
              rdata_d[i][16]      = drop_q[i];
            end
          end
          default: fault_d[i] = 1'b1;
        endcase
      end
    end
    // A drop in the same cycle as a clear leaves the bit set.
    drop_d = (drop_q & ~drop_clr) | drop_set;
  end

  always_comb begin
    for (int d = 0; d < CORES; d++) begin
      wptr_d[d] = wptr_q[d] + PW'(push_en[d]);
      rptr_d[d] = rptr_q[d] + PW'(pop_en[d]);
      cnt_d[d]  = cnt_q[d] + CW'(push_en[d]) - CW'(pop_en[d]);
      irq_d[d]  = (cnt_d[d] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
      pend_q  <= '0;
      fault_q <= '0;
      rdata_q <= '0;
      irq_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
      pend_q  <= acc;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < CORES; d++) begin
      if (push_en[d]) mem_q[d][wptr_q[d]] <= tx_word;
    end
  end

  assign csr_rsp_valid_o = pend_q;
  assign csr_rsp_rdata_o = rdata_q;
  assign csr_rsp_fault_o = fault_q;
  assign ipi_irq_o       = irq_q;

endmodule

// File: tb/tb_ipi_mailbox.sv
// Directed bench for ipi_mailbox with two cores and 4-deep RX FIFOs.
module tb_ipi_mailbox;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      valid = '0;
  logic [1:0]      ready;
  logic [1:0]      write = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0][3:0] wstrb = '0;
  logic [1:0][1:0] priv = '0;
  logic [1:0]      rsp_valid;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]      rsp_fault;
  logic [1:0]      irq;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ipi_mailbox #(.CORES(2), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req_valid_i(valid), .csr_req_ready_o(ready), .csr_req_write_i(write),
    .csr_req_addr_i(addr), .csr_req_wdata_i(wdata), .csr_req_wstrb_i(wstrb),
    .csr_req_priv_i(priv), .csr_rsp_valid_o(rsp_valid), .csr_rsp_rdata_o(rsp_rdata),
    .csr_rsp_fault_o(rsp_fault), .ipi_irq_o(irq)
  );

  // Drives one request on core c and returns at the negedge where its response is visible.
  task automatic csr(input int c, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rd, output logic flt);
    int n = 0;
    @(negedge clk);
    valid[c] = 1'b1; write[c] = wr; addr[c] = a; wdata[c] = wd; wstrb[c] = strb;
    #1;
    while (!ready[c] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL csr_timeout: core %0d ready got 0 want 1", c);
      valid[c] = 1'b0; rd = '0; flt = 1'b1;
      return;
    end
    @(negedge clk);
    valid[c] = 1'b0;
    rd = rsp_rdata[c]; flt = rsp_fault[c];
  endtask

  task automatic test_reset;
    #12;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    tests++; if (rsp_fault !== 2'b00) begin fails++; $display("FAIL reset_rsp_fault: got %b want 00", rsp_fault); end
    tests++; if (rsp_rdata !== 64'h0) begin fails++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    tests++; if (irq !== 2'b00) begin fails++; $display("FAIL reset_irq: got %b want 00", irq); end
    tests++; if (ready !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b want 11", ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic f;
    csr(0, 1'b1, 32'h0, 32'h2, 4'hF, rd, f);
    tests++; if (f !== 1'b0) begin fails++; $display("FAIL basic_mask_fault: got %b want 0", f); end
    csr(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, f);
    tests++; if (f !== 1'b0) begin fails++; $display("FAIL basic_tx_fault: got %b want 0", f); end
    tests++; if (rsp_valid[0] !== 1'b1) begin fails++; $display("FAIL basic_rsp_valid: got %b want 1", rsp_valid[0]); end
    tests++; if (irq !== 2'b10) begin fails++; $display("FAIL basic_irq_rise: got %b want 10", irq); end
    @(negedge clk);
    tests++; if (rsp_valid[0] !== 1'b0) begin fails++; $display("FAIL basic_rsp_pulse: got %b want 0", rsp_valid[0]); end
    csr(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'hDEADBEEF || f !== 1'b0) begin fails++; $display("FAIL basic_rx: got %h/%b want deadbeef/0", rd, f); end
    @(negedge clk);
    tests++; if (irq !== 2'b00) begin fails++; $display("FAIL basic_irq_fall: got %b want 00", irq); end
  endtask

  task automatic test_broadcast;
    logic [31:0] rd; logic f;
    logic [31:0] exp [2] = '{32'h11, 32'h22};
    csr(0, 1'b1, 32'h0, 32'h3, 4'hF, rd, f);
    csr(0, 1'b1, 32'h4, 32'h11, 4'hF, rd, f);
    csr(0, 1'b1, 32'h4, 32'h22, 4'hF, rd, f);
    for (int c = 0; c < 2; c++) begin
      csr(c, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
      tests++; if (rd !== 32'h0000_0201) begin fails++; $display("FAIL bcast_status%0d: got %h want 00000201", c, rd); end
      for (int k = 0; k < 2; k++) begin
        csr(c, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
        tests++; if (rd !== exp[k]) begin fails++; $display("FAIL bcast_rx%0d_%0d: got %h want %h", c, k, rd, exp[k]); end
      end
      csr(c, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
      tests++; if (rd !== 32'h0 || f !== 1'b0) begin fails++; $display("FAIL bcast_empty%0d: got %h/%b want 0/0", c, rd, f); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] rd; logic f;
    csr(1, 1'b1, 32'h0, 32'h1, 4'hF, rd, f);
    for (int k = 0; k < 5; k++) csr(1, 1'b1, 32'h4, 32'hA0 + k, 4'hF, rd, f);
    csr(1, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'h0001_0000) begin fails++; $display("FAIL ovf_drop_status: got %h want 00010000", rd); end
    csr(0, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'h0000_0403) begin fails++; $display("FAIL ovf_full_status: got %h want 00000403", rd); end
    for (int k = 0; k < 4; k++) begin
      csr(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
      tests++; if (rd !== 32'hA0 + k) begin fails++; $display("FAIL ovf_rx%0d: got %h want %h", k, rd, 32'hA0 + k); end
    end
    csr(1, 1'b1, 32'hC, 32'h0001_0000, 4'hF, rd, f);
    csr(1, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ovf_w1c: got %h want 0", rd); end
  endtask

  task automatic test_contention;
    logic [31:0] rd; logic f;
    csr(0, 1'b1, 32'h0, 32'h1, 4'hF, rd, f);
    @(negedge clk);
    valid = 2'b11; write = 2'b11; addr = {32'h4, 32'h4};
    wdata = {32'hC1, 32'hC0}; wstrb = {4'hF, 4'hF};
    #1;
    tests++; if (ready !== 2'b01) begin fails++; $display("FAIL cont_ready_first: got %b want 01", ready); end
    @(negedge clk);
    valid[0] = 1'b0;
    #1;
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL cont_rsp_first: got %b want 01", rsp_valid); end
    tests++; if (ready[1] !== 1'b1) begin fails++; $display("FAIL cont_ready_second: got %b want 1", ready[1]); end
    @(negedge clk);
    valid[1] = 1'b0;
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL cont_rsp_second: got %b want 10", rsp_valid); end
    csr(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'hC0) begin fails++; $display("FAIL cont_rx0: got %h want c0", rd); end
    csr(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'hC1) begin fails++; $display("FAIL cont_rx1: got %h want c1", rd); end
  endtask

  task automatic test_faults;
    logic [31:0] rd; logic f;
    csr(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, f);
    tests++; if (f !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL fault_rd10: got %h/%b want 0/1", rd, f); end
    csr(0, 1'b1, 32'h8, 32'h5, 4'hF, rd, f);
    tests++; if (f !== 1'b1) begin fails++; $display("FAIL fault_wr8: got %b want 1", f); end
    csr(0, 1'b1, 32'h4, 32'h77, 4'h1, rd, f);
    tests++; if (f !== 1'b1) begin fails++; $display("FAIL fault_strb: got %b want 1", f); end
    csr(0, 1'b0, 32'h2, 32'h0, 4'hF, rd, f);
    tests++; if (f !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL fault_unaligned: got %h/%b want 0/1", rd, f); end
    csr(0, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL fault_status_kept: got %h want 0", rd); end
    csr(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, f);
    tests++; if (rd !== 32'h1) begin fails++; $display("FAIL fault_mask_kept: got %h want 1", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic f;
    csr(0, 1'b1, 32'h0, 32'h3, 4'hF, rd, f);
    csr(0, 1'b1, 32'h4, 32'h55, 4'hF, rd, f);
    tests++; if (irq !== 2'b11) begin fails++; $display("FAIL rmid_irq_pre: got %b want 11", irq); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (irq !== 2'b00) begin fails++; $display("FAIL rmid_irq_async: got %b want 00", irq); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      csr(c, 1'b0, 32'hC, 32'h0, 4'hF, rd, f);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rmid_status%0d: got %h want 0", c, rd); end
      csr(c, 1'b0, 32'h0, 32'h0, 4'hF, rd, f);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rmid_mask%0d: got %h want 0", c, rd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_broadcast();
    test_overflow();
    test_contention();
    test_faults();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ipi_mailbox.md
# ipi_mailbox

Inter-processor interrupt mailbox for a CORES-way cluster. Each core owns one CSR port carrying a destination mask, a transmit data register and its own receive FIFO. A write to TX_DATA broadcasts one word into the RX FIFO of every core selected by the sender's mask. A core's `ipi_irq` bit is high while its RX FIFO holds data. The block sits on the per-core CSR fabric beside the other system CSR blocks.

## Interface
- `CORES`, 2: number of cores and CSR ports, 1..32.
- `DATA_W`, 32: message width, ≤ 32; register reads zero-extend.
- `FIFO_DEPTH`, 4: entries per RX FIFO, power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `csr`  csr_if slave modport  array [CORES]: per-core CSR port. Request fields: `req_valid`, `req_ready`, `req_write`, `req_addr[31:0]`, `req_wdata[31:0]`, `req_wstrb[3:0]`, `req_priv[1:0]`. Response fields: `rsp_valid`, `rsp_rdata[31:0]`, `rsp_fault`.
- `ipi_irq`  out  CORES: bit i = RX FIFO of core i is non-empty.

## Operation
Register map, per port, on `req_addr[7:0]`; upper address bits are ignored:
- 0x0 SEND_MASK, RW. Bits [CORES-1:0] are the destination mask; higher bits read 0. Writes honour `wstrb` per byte. Self-send is allowed.
- 0x4 TX_DATA, WO. An accepted write pushes `wdata[DATA_W-1:0]` into every RX FIFO selected by this core's SEND_MASK. Requires `wstrb`=4'hF, otherwise fault with no push. Reads return 0 without fault.
- 0x8 RX_DATA, RO. A read returns the head of this core's FIFO and pops it. Reading an empty FIFO returns 0, does not pop and does not fault. Writes fault.
- 0xC STATUS. Fields:
  - [0]: rx non-empty.
  - [1]: rx full.
  - [15:8]: rx count.
  - [16]: TX_DROP sticky, write-1-to-clear.
- Any other offset, or `req_addr[1:0]` ≠ 0: fault, no side effects, `rdata`=0.
- `req_priv` is ignored; all privilege levels have access.

Push rules:
- A destination whose FIFO is full (count = FIFO_DEPTH before this cycle's pop) drops the word.
- Delivery to all other destinations proceeds.
- The sender's TX_DROP bit is set.
- A mask of 0 is a no-op.

Arbitration:
- Only one TX_DATA write is accepted per cycle; the lowest-index requesting core wins.
- Losing cores see `req_ready`=0 that cycle and hold their request.
- All other accesses are never stalled.

Simultaneous push and pop on one FIFO: both take effect and the count is unchanged. A full FIFO still drops the push even if it is popped in the same cycle.

Reset (asynchronous): all FIFOs empty, pointers 0, SEND_MASK=0, TX_DROP=0, `ipi_irq`=0, `rsp_valid`=0, `rsp_fault`=0, `rsp_rdata`=0. A transaction in flight at reset is discarded.

## Timing
- `req_ready` is combinational. It is 1 unless the port has a response pending, or it loses TX arbitration.
- A request is accepted on the cycle where `req_valid & req_ready`.
- Response: `rsp_valid` is pulsed for exactly one cycle, in the cycle after acceptance, with `rsp_rdata` and `rsp_fault`. There is no response backpressure.
- One outstanding request per port.
- FIFO state, SEND_MASK and `ipi_irq` update at the acceptance edge. Consequently:
  - `ipi_irq[d]` rises in the cycle after a TX_DATA acceptance.
  - `ipi_irq[d]` falls in the cycle after the RX_DATA acceptance that empties the FIFO.
- `ipi_irq` is a register output, glitch-free.
- RX_DATA read data is the head value sampled at acceptance.
- The STATUS count is 0..FIFO_DEPTH and needs $clog2(FIFO_DEPTH)+1 bits.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Test plan
- **Basic send/receive:** core0 writes SEND_MASK=0x2, then TX_DATA=0xDEADBEEF.
  - No fault on either write.
  - `ipi_irq[1]`=1 within 5 cycles; `ipi_irq[0]`=0.
  - Core1 reads 0x8 and gets 0xDEADBEEF, no fault.
  - `ipi_irq[1]`=0 two cycles later.
- **Broadcast and ordering:** core0 sets mask 0x3 and sends 0x11 then 0x22.
  - Both cores' STATUS count = 2.
  - Each core reads 0x11 then 0x22.
  - A further RX read returns 0 without fault.
- **Overflow:** core1 sends to core0 five times with FIFO_DEPTH=4.
  - Core1 STATUS[16]=1; core0 STATUS = full, count 4.
  - The first four words read back in order.
  - Writing 0x10000 to core1 STATUS clears the TX_DROP bit.
- **Contention:** both cores write TX_DATA to core0 in the same cycle.
  - Core0's write is accepted first; core1 stalls one cycle.
  - Core0's FIFO holds the core0 word, then the core1 word.
- **Faults:** the following each return `rsp_fault`=1 and leave state unchanged:
  - a read of 0x10;
  - a write to 0x8;
  - a TX_DATA write with `wstrb`=4'h1;
  - an access to 0x2.
- **Reset mid-traffic:** assert `rst_n` low with both FIFOs non-empty.
  - `ipi_irq`=0 immediately.
  - After release, STATUS=0 and SEND_MASK=0.
